// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial pattern detector with runtime pattern load and overlap control.
// Define SEQ_DET_COUNT_EN to build the saturating match_count register; otherwise match_count is tied to 0.
module seq_detector_param #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   x,
    input  logic                   load,
    input  logic [PATTERN_LEN-1:0] pat_in,
    output logic                   z,
    output logic [CNT_W-1:0]       match_count
);

    localparam int FILL_W = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;

    localparam logic [FILL_W-1:0] FILL_EMPTY  = '0;
    localparam logic [FILL_W-1:0] FILL_PRIMED = FILL_W'(PATTERN_LEN - 1);

    logic [PATTERN_LEN-1:0] pat_r;
    logic [PATTERN_LEN-2:0] hist;
    logic [FILL_W-1:0]      fill;
    logic [PATTERN_LEN-1:0] window;
    logic                   accept;
    logic                   primed;

    // The candidate window is the stored history with the live bit appended, so z needs no extra cycle.
    assign window = {hist, x};
    assign accept = en & ~load;
    assign primed = (fill == FILL_PRIMED);
    assign z      = reset & accept & primed & (window == pat_r);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pat_r <= PATTERN;
            hist  <= '0;
            fill  <= FILL_EMPTY;
        end else if (load) begin
            pat_r <= pat_in;
            hist  <= '0;
            fill  <= FILL_EMPTY;
        end else if (en) begin
            // Without overlap, a match consumes every bit it used, including the current one.
            if (z && !OVERLAP) begin
                hist <= '0;
                fill <= FILL_EMPTY;
            end else begin
                hist <= window[PATTERN_LEN-2:0];
                if (!primed) begin
                    fill <= fill + FILL_W'(1);
                end
            end
        end
    end

`ifdef SEQ_DET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            match_count <= '0;
        end else if (z && (match_count != CNT_MAX)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end
`else
    assign match_count = '0;
`endif

endmodule
